udp_imem_loader: RTL and testbench
==================================

// Module: udp_imem_loader
// PURPOSE
// Downstream consumer of the UDP receive buffer (udp_icache, 512x32). On each rx_finish
// rising edge, reads the buffered frame, checks header, copies the payload into RV32
// instruction memory and verifies a checksum. Holds the CPU in reset until a load passes.
// PARAMETERS
// BUF_AW   9             receive-buffer address width (2**BUF_AW words)
// IMEM_AW  10            instruction-memory word-address width
// MAGIC    32'h52563332  required value of buffer word 0 ("RV32")
// PORTS
// clock         in   1        single clock; buffer read and imem write are synchronous to it
// rst           in   1        asynchronous reset, active-high
// rx_finish     in   1        frame-complete level from udp; rising edge starts a load
// buf_rd_en     out  1        buffer read enable
// buf_rd_addr   out  BUF_AW   buffer word address
// buf_rd_data   in   32       buffer data, valid 1 cycle after buf_rd_en/addr
// imem_wr_en    out  1        instruction-memory write strobe
// imem_wr_addr  out  IMEM_AW  imem word address
// imem_wr_data  out  32       imem write data
// cpu_rst_hold  out  1        1 = keep CPU in reset
// load_done     out  1        last load passed (level)
// load_err      out  1        last load failed (level)
// err_code      out  2        0 none, 1 bad magic, 2 bad length/range, 3 checksum mismatch
// word_count    out  16       payload words written by current/last load
// BEHAVIOUR
// - Reset (async): all outputs 0 except cpu_rst_hold=1; FSM=IDLE; rx_finish edge reg=0.
// - Frame: w0=MAGIC; w1={base[15:0],len[15:0]}; w2..w(len+1)=payload; w(len+2)=checksum
//   = sum of payload words mod 2**32.
// - FSM: IDLE->HDR0->HDR1->PAYLOAD->CSUM->DONE|ERR. Cycle 0 = rx_finish sampled 1, prev 0.
//   Cycle 1: enter HDR0, buf_rd_en=1, addr 0. Addr k issued cycle 1+k, data at 2+k.
//   Addresses issue back-to-back; issuing stops after addr len+2. Reading past end is harmless.
// - HDR0 (cycle 2): w0!=MAGIC -> ERR code 1 at cycle 3.
// - HDR1 (cycle 3): len==0, len+3 > 2**BUF_AW, or base+len > 2**IMEM_AW -> ERR code 2 at cycle 4.
// - PAYLOAD: payload word k (data cycle 4+k) -> imem_wr_en=1, addr=base+k (low IMEM_AW bits),
//   data=word, in cycle 5+k. Accumulate sum; word_count increments per write.
// - CSUM: checksum word valid cycle len+4; DONE or ERR(3) registered at cycle len+5.
// - DONE: load_done=1, load_err=0, cpu_rst_hold=0. ERR: load_err=1, load_done=0,
//   cpu_rst_hold=1, buf_rd_en=0 from ERR entry. Writes already done are not undone.
// - Start of any load: load_done=0, load_err=0, err_code=0, word_count=0, cpu_rst_hold=1.
// - rx_finish edges outside IDLE/DONE/ERR are ignored. A level held high starts one load only.
//   A new edge in DONE/ERR restarts the load.
// - imem_wr_en is single-cycle per word and never asserted outside PAYLOAD writes.
// - Async reset mid-load aborts immediately: strobes drop the same instant, no further writes.
// TESTING
// - len=4, base=0x010, payload 1,2,3,4, csum=10 -> imem writes 0x010..0x013 in cycles 5..8;
//   load_done=1, cpu_rst_hold=0 at cycle 9; word_count=4.
// - w0=0xDEADBEEF -> load_err=1, err_code=1 at cycle 3; no imem_wr_en; cpu_rst_hold stays 1.
// - len=0, then base=0x3FE len=4 (IMEM_AW=10) -> err_code=2 at cycle 4; zero writes each.
// - len=2, payload 0xFFFFFFFF,0x2, csum=0x1 (wrap) -> done. Same frame with csum=0x3 -> err_code=3,
//   2 writes made, cpu_rst_hold=1.
// - rx_finish held high 20 cycles -> exactly one load. Second edge after DONE -> load_done
//   clears, full reload, done again.
// - Assert rst during PAYLOAD after 2 of 4 writes -> outputs at reset values asynchronously.
//   Next rx_finish edge -> complete load from word 0.

Source files
------------

// File: rtl/udp_imem_loader.sv
// udp_imem_loader: reads a framed program image out of the UDP receive buffer,
// validates the header, copies the payload into instruction memory and checks a
// running 32-bit sum. The CPU is kept in reset until a load completes cleanly.
module udp_imem_loader #(
    parameter int          BUF_AW  = 9,
    parameter int          IMEM_AW = 10,
    parameter logic [31:0] MAGIC   = 32'h52563332
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               rx_finish,
    output logic               buf_rd_en,
    output logic [BUF_AW-1:0]  buf_rd_addr,
    input  logic [31:0]        buf_rd_data,
    output logic               imem_wr_en,
    output logic [IMEM_AW-1:0] imem_wr_addr,
    output logic [31:0]        imem_wr_data,
    output logic               cpu_rst_hold,
    output logic               load_done,
    output logic               load_err,
    output logic [1:0]         err_code,
    output logic [15:0]        word_count
);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, PAYLOAD, CSUM, DONE, ERR} state_e;

    state_e               state_q, state_d;
    logic                 rx_prev_q, rx_prev_d;
    logic                 rd_en_q, rd_en_d;
    logic [BUF_AW-1:0]    rd_addr_q, rd_addr_d;
    logic                 rd_vld_q, rd_vld_d;
    logic [15:0]          base_q, base_d;
    logic [15:0]          len_q, len_d;
    logic [15:0]          pay_idx_q, pay_idx_d;
    logic [31:0]          sum_q, sum_d;
    logic                 wr_en_q, wr_en_d;
    logic [IMEM_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic                 hold_q, hold_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic [15:0]          cnt_q, cnt_d;

    logic                 start;
    logic [15:0]          hdr_base, hdr_len;
    logic                 hdr_bad;
    logic                 rd_last;

    // A load starts only on a fresh rising edge while no load is in flight.
    assign start    = rx_finish && !rx_prev_q && (state_q inside {IDLE, DONE, ERR});
    assign hdr_base = buf_rd_data[31:16];
    assign hdr_len  = buf_rd_data[15:0];
    // Frame must carry payload, fit in the buffer with its 3 overhead words, and fit in imem.
    assign hdr_bad  = (hdr_len == 16'd0)
                   || ({16'd0, hdr_len} + 32'd3 > (32'd1 << BUF_AW))
                   || ({16'd0, hdr_base} + {16'd0, hdr_len} > (32'd1 << IMEM_AW));
    // Length is only known from PAYLOAD on; before that the address (<=2) cannot be the last one.
    assign rd_last  = (state_q == PAYLOAD || state_q == CSUM)
                   && ({{(16-BUF_AW){1'b0}}, rd_addr_q} == len_q + 16'd2);

    // State register plus all datapath/output flops; reset aborts a load instantly.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rx_prev_q <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_vld_q  <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            pay_idx_q <= '0;
            sum_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rx_prev_q <= rx_prev_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_vld_q  <= rd_vld_d;
            base_q    <= base_d;
            len_q     <= len_d;
            pay_idx_q <= pay_idx_d;
            sum_q     <= sum_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state: walk the frame word by word as buffer data returns.
    // NOTE: the default assignment up front keeps this combinational block latch-free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) state_d = HDR0;
            HDR0:            if (rd_vld_q) state_d = (buf_rd_data == MAGIC) ? HDR1 : ERR;
            HDR1:            state_d = hdr_bad ? ERR : PAYLOAD;
            PAYLOAD:         if (pay_idx_q == len_q - 16'd1) state_d = CSUM;
            CSUM:            state_d = (buf_rd_data == sum_q) ? DONE : ERR;
            default:         state_d = IDLE;
        endcase
    end

    // Outputs/datapath: read issue, header capture, imem writes, sum and status.
    always_comb begin
        rx_prev_d = rx_finish;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        rd_vld_d  = rd_en_q;
        base_d    = base_q;
        len_d     = len_q;
        pay_idx_d = pay_idx_q;
        sum_d     = sum_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        done_d    = done_q;
        err_d     = err_q;
        code_d    = code_q;
        cnt_d     = cnt_q;

        if (start) begin
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
            pay_idx_d = '0;
            sum_d     = '0;
            hold_d    = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b0;
            code_d    = 2'd0;
            cnt_d     = '0;
        end else if (rd_en_q) begin
            if (rd_last) rd_en_d   = 1'b0;
            else         rd_addr_d = rd_addr_q + 1'b1;
        end

        case (state_q)
            HDR0: if (rd_vld_q && buf_rd_data != MAGIC) code_d = 2'd1;
            HDR1: begin
                base_d = hdr_base;
                len_d  = hdr_len;
                if (hdr_bad) code_d = 2'd2;
            end
            PAYLOAD: begin
                wr_en_d   = 1'b1;
                wr_addr_d = IMEM_AW'(base_q + pay_idx_q);
                wr_data_d = buf_rd_data;
                sum_d     = sum_q + buf_rd_data;
                cnt_d     = cnt_q + 16'd1;
                pay_idx_d = pay_idx_q + 16'd1;
            end
            CSUM: if (buf_rd_data != sum_q) code_d = 2'd3;
            default: ;
        endcase

        if (state_d == ERR && state_q != ERR) begin
            err_d   = 1'b1;
            done_d  = 1'b0;
            hold_d  = 1'b1;
            rd_en_d = 1'b0;
        end
        if (state_d == DONE && state_q != DONE) begin
            done_d = 1'b1;
            err_d  = 1'b0;
            hold_d = 1'b0;
        end
    end

    assign buf_rd_en    = rd_en_q;
    assign buf_rd_addr  = rd_addr_q;
    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign cpu_rst_hold = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign err_code     = code_q;
    assign word_count   = cnt_q;

endmodule

// File: tb/tb_udp_imem_loader.sv
// Self-checking bench for udp_imem_loader: a 512x32 synchronous buffer model feeds
// frames; a frame-level reference derives outcome, timing and expected imem writes.
module tb_udp_imem_loader;

    localparam logic [31:0] MAGIC = 32'h52563332;

    logic        clock, rst, rx_finish;
    logic        buf_rd_en;
    logic [8:0]  buf_rd_addr;
    logic [31:0] buf_rd_data;
    logic        imem_wr_en;
    logic [9:0]  imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        cpu_rst_hold, load_done, load_err;
    logic [1:0]  err_code;
    logic [15:0] word_count;

    logic [31:0] buf_mem [512];
    logic [31:0] pl [$];
    int          checks = 0;
    int          errors = 0;

    udp_imem_loader dut (
        .clock        (clock),
        .rst          (rst),
        .rx_finish    (rx_finish),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_addr  (buf_rd_addr),
        .buf_rd_data  (buf_rd_data),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_rst_hold (cpu_rst_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .err_code     (err_code),
        .word_count   (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Receive buffer: data for the address presented one cycle earlier.
    always @(posedge clock) if (buf_rd_en) buf_rd_data <= buf_mem[buf_rd_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Fill the buffer with junk, then lay the frame over it. Payload comes from pl, else random.
    task automatic make_frame(input logic [31:0] magic, input int base, input int len,
                              input logic [31:0] csum_xor);
        logic [31:0] sum;
        sum = 32'd0;
        for (int i = 0; i < 512; i++) buf_mem[i] = $urandom;
        buf_mem[0] = magic;
        buf_mem[1] = {base[15:0], len[15:0]};
        for (int k = 0; k < len && 2 + k < 512; k++) begin
            buf_mem[2+k] = (k < pl.size()) ? pl[k] : $urandom;
            sum += buf_mem[2+k];
        end
        if (len + 2 < 512) buf_mem[len+2] = sum ^ csum_xor;
        pl.delete();
    endtask

    // Run one load from a clean rx_finish edge and compare against the frame-level reference.
    task automatic run_load(input string name, input int hold);
        int unsigned base, len, exp_code, exp_t, exp_last, exp_nwr, n_cyc;
        logic [31:0] sum;
        int          done_cyc, nwr;
        bit          rd_ok, wr_ok, start_ok;

        base = buf_mem[1][31:16];
        len  = buf_mem[1][15:0];
        if (buf_mem[0] != MAGIC) begin
            exp_code = 1; exp_t = 3; exp_last = 2; exp_nwr = 0;
        end else if (len == 0 || len + 3 > 512 || base + len > 1024) begin
            exp_code = 2; exp_t = 4; exp_last = 3; exp_nwr = 0;
        end else begin
            sum = 32'd0;
            for (int k = 0; k < int'(len); k++) sum += buf_mem[2+k];
            exp_code = (sum == buf_mem[len+2]) ? 0 : 3;
            exp_t = len + 5; exp_last = len + 3; exp_nwr = len;
        end

        n_cyc    = ((exp_t > hold) ? exp_t : hold) + 6;
        done_cyc = -1;
        nwr      = 0;
        rd_ok    = 1'b1;
        wr_ok    = 1'b1;
        start_ok = 1'b0;

        rx_finish = 1'b0;
        @(posedge clock); #1;
        rx_finish = 1'b1;
        for (int c = 1; c <= int'(n_cyc); c++) begin
            @(posedge clock); #1;
            if (c == hold) rx_finish = 1'b0;
            if (c == 1)
                start_ok = !load_done && !load_err && cpu_rst_hold
                        && err_code == 2'd0 && word_count == 16'd0;
            if (buf_rd_en !== (c <= int'(exp_last))) rd_ok = 1'b0;
            if (buf_rd_en === 1'b1 && int'(buf_rd_addr) != c - 1) rd_ok = 1'b0;
            if (imem_wr_en !== 1'b0) begin
                if (nwr >= int'(exp_nwr) || c != 5 + nwr
                    || imem_wr_addr !== 10'((base + nwr) & 32'h3FF)
                    || imem_wr_data !== buf_mem[2+nwr])
                    wr_ok = 1'b0;
                nwr++;
            end
            if (done_cyc < 0 && (load_done === 1'b1 || load_err === 1'b1)) done_cyc = c;
        end
        rx_finish = 1'b0;

        check({name, ".start_clear"}, 64'(start_ok), 64'd1);
        check({name, ".rd_seq"},      64'(rd_ok),    64'd1);
        check({name, ".wr_seq"},      64'(wr_ok),    64'd1);
        check({name, ".n_writes"},    64'(nwr),      64'(exp_nwr));
        check({name, ".done_cycle"},  64'(done_cyc), 64'(exp_t));
        check({name, ".load_done"},   64'(load_done), 64'(exp_code == 0));
        check({name, ".load_err"},    64'(load_err),  64'(exp_code != 0));
        check({name, ".err_code"},    64'(err_code),  64'(exp_code));
        check({name, ".word_count"},  64'(word_count), 64'(exp_nwr));
        check({name, ".cpu_hold"},    64'(cpu_rst_hold), 64'(exp_code != 0));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".rd_en"},    64'(buf_rd_en),    64'd0);
        check({name, ".wr_en"},    64'(imem_wr_en),   64'd0);
        check({name, ".cpu_hold"}, 64'(cpu_rst_hold), 64'd1);
        check({name, ".done"},     64'(load_done),    64'd0);
        check({name, ".err"},      64'(load_err),     64'd0);
        check({name, ".code"},     64'(err_code),     64'd0);
        check({name, ".wcount"},   64'(word_count),   64'd0);
    endtask

    initial begin
        int kind, len, base;

        rst = 1'b1;
        rx_finish = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clock); #1;
        rst = 1'b0;

        // Basic good load.
        pl = '{32'd1, 32'd2, 32'd3, 32'd4};
        make_frame(MAGIC, 16'h010, 4, 32'd0);
        run_load("basic", 1);

        // Header failures.
        make_frame(32'hDEADBEEF, 16'h010, 4, 32'd0);
        run_load("bad_magic", 1);
        make_frame(MAGIC, 16'h010, 0, 32'd0);
        run_load("len_zero", 1);
        make_frame(MAGIC, 16'h3FE, 4, 32'd0);
        run_load("imem_range", 1);
        make_frame(MAGIC, 0, 510, 32'd0);
        run_load("buf_range", 2);

        // Exact boundaries that must still pass.
        make_frame(MAGIC, 16'h3FC, 4, 32'd0);
        run_load("imem_edge", 1);
        make_frame(MAGIC, 0, 509, 32'd0);
        run_load("buf_edge", 1);

        // Checksum wrap, then the same frame with a wrong checksum.
        pl = '{32'hFFFFFFFF, 32'h2};
        make_frame(MAGIC, 16'h100, 2, 32'd0);
        run_load("csum_wrap", 1);
        pl = '{32'hFFFFFFFF, 32'h2};
        make_frame(MAGIC, 16'h100, 2, 32'd2);
        run_load("csum_bad", 1);

        // Level held high gives a single load; a fresh edge after DONE reloads.
        make_frame(MAGIC, 16'h020, 4, 32'd0);
        run_load("held", 20);
        run_load("reload", 1);

        // Reset in the middle of the payload, then a full load from word 0.
        make_frame(MAGIC, 16'h040, 4, 32'd0);
        rx_finish = 1'b0;
        @(posedge clock); #1;
        rx_finish = 1'b1;
        repeat (6) begin
            @(posedge clock); #1;
            rx_finish = 1'b0;
        end
        check("pre_rst.wcount", 64'(word_count), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        repeat (3) begin
            @(posedge clock); #1;
            check("in_rst.wr_en", 64'(imem_wr_en), 64'd0);
        end
        rst = 1'b0;
        run_load("post_rst", 1);

        // Randomized frames covering all outcomes.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            len  = int'($urandom_range(1, 12));
            base = int'($urandom_range(0, 1024 - len));
            case (kind)
                0: make_frame(MAGIC ^ (32'd1 << $urandom_range(0, 31)), base, len, 32'd0);
                1: make_frame(MAGIC, base, ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(510, 700)), 32'd0);
                2: make_frame(MAGIC, 1024 - len + int'($urandom_range(1, 40)), len, 32'd0);
                3: make_frame(MAGIC, base, len, $urandom | 32'd1);
                default: make_frame(MAGIC, base, len, 32'd0);
            endcase
            run_load($sformatf("rand%0d", n), int'($urandom_range(1, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
